// File: rtl/accel_mc_pkg.sv
// Shared types and register map for the multi-channel arithmetic accelerator.
package accel_mc_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_SUB    = 2'd1,
        OP_SATADD = 2'd2,
        OP_MUL    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_EXEC,
        ST_WB
    } eng_state_e;

    // Byte offsets within a channel page (0x00-0x7F) and within the global page (0x80-0x8F)
    localparam logic [3:0] OFF_A      = 4'h0;
    localparam logic [3:0] OFF_B      = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_RESULT = 4'hC;
    localparam logic [3:0] OFF_DONE   = 4'h0;
    localparam logic [3:0] OFF_IRQ_EN = 4'h4;
    localparam logic [3:0] OFF_OVF    = 4'h8;
    localparam logic [3:0] OFF_ID     = 4'hC;
    localparam logic [3:0] GLB_PAGE   = 4'h8;

    localparam int unsigned CTRL_START_BIT = 8;
    localparam int unsigned CTRL_PEND_BIT  = 9;

    localparam logic [7:0] ID_MAGIC = 8'hAC;
    localparam logic [7:0] ID_REV   = 8'h01;

    function automatic logic [31:0] id_word(input int unsigned num_ch, input int unsigned data_w);
        return {ID_MAGIC, num_ch[7:0], data_w[7:0], ID_REV};
    endfunction

endpackage

// File: rtl/accel_mc_engine.sv
// Shared sequential engine: round-robin grant over pending channels, 1-cycle ADD/SUB/SATADD,
// DATA_W-cycle shift-add MUL, one-cycle completion strobe carrying the channel index.
module accel_mc_engine
    import accel_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pending,
    input  logic [DATA_W-1:0] a_regs  [NUM_CH],
    input  logic [DATA_W-1:0] b_regs  [NUM_CH],
    input  op_e               op_regs [NUM_CH],
    output logic              done,
    output logic [CH_W-1:0]   done_ch,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    eng_state_e          state_q, state_d;
    logic [CH_W-1:0]     ptr_q, gnt_q, sel;
    op_e                 op_q;
    logic [2*DATA_W-1:0] a_sh, acc;
    logic [DATA_W-1:0]   b_sh;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [DATA_W:0]     sum, diff;

    // First pending channel at or after the round-robin pointer
    always_comb begin
        int unsigned j;
        logic found;
        sel   = ptr_q;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && pending[j]) begin
                sel   = CH_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sum  = {1'b0, a_sh[DATA_W-1:0]} + {1'b0, b_sh};
        diff = {1'b0, a_sh[DATA_W-1:0]} - {1'b0, b_sh};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|pending) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_EXEC;
            ST_EXEC:  if (op_q != OP_MUL || cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_q    <= OP_ADD;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_GRANT: begin
                    gnt_q <= sel;
                    op_q  <= op_regs[sel];
                    a_sh  <= {{DATA_W{1'b0}}, a_regs[sel]};
                    b_sh  <= b_regs[sel];
                    acc   <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            acc   <= {{DATA_W{1'b0}}, sum[DATA_W-1:0]};
                            ovf_q <= sum[DATA_W];
                        end
                        OP_SUB: begin
                            acc   <= {{DATA_W{1'b0}}, diff[DATA_W-1:0]};
                            ovf_q <= diff[DATA_W];
                        end
                        OP_SATADD: begin
                            acc   <= {{DATA_W{1'b0}}, (sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0])};
                            ovf_q <= sum[DATA_W];
                        end
                        default: begin
                            if (b_sh[0]) acc <= acc + a_sh;
                            a_sh  <= a_sh << 1;
                            b_sh  <= b_sh >> 1;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    endcase
                end
                ST_WB: ptr_q <= (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + CH_W'(1);
                default: ;
            endcase
        end
    end

    assign done    = (state_q == ST_WB);
    assign done_ch = gnt_q;
    assign result  = acc[DATA_W-1:0];
    assign ovf     = (op_q == OP_MUL) ? |acc[2*DATA_W-1:DATA_W] : ovf_q;

endmodule

// File: rtl/accel_mc_top.sv
// Wishbone slave front end: address decode, per-channel register sets, DONE/OVF/IRQ_EN and read mux.
module accel_mc_top
    import accel_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADR_W  = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    input  logic [ADR_W-1:0] wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    output logic             int_o
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] a_q [NUM_CH];
    logic [DATA_W-1:0] b_q [NUM_CH];
    logic [DATA_W-1:0] res_q [NUM_CH];
    op_e               op_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q, done_q, ovf_q, irq_en_q;

    logic              eng_done, eng_ovf;
    logic [CH_W-1:0]   eng_ch;
    logic [DATA_W-1:0] eng_result;

    logic [2:0]        adr_ch;
    logic [3:0]        adr_off;
    logic [CH_W-1:0]   ch;
    logic              in_ch, in_glb, req, dec_err, wr_fire;
    logic              wr_a, wr_b, wr_ctrl, irq_wr;
    logic [NUM_CH-1:0] done_clr, ovf_clr, start_mask, eng_mask;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign adr_ch  = wb_adr_i[6:4];
    assign adr_off = {wb_adr_i[3:2], 2'b00};
    assign ch      = CH_W'(adr_ch);
    assign in_ch   = (wb_adr_i[ADR_W-1:7] == '0) && (32'(adr_ch) < NUM_CH);
    assign in_glb  = (wb_adr_i[ADR_W-1:4] == (ADR_W-4)'(GLB_PAGE));
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr_fire = req & ~dec_err & wb_we_i;

    always_comb begin
        dec_err  = 1'b1;
        rdata    = '0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        wr_ctrl  = 1'b0;
        irq_wr   = 1'b0;
        done_clr = '0;
        ovf_clr  = '0;
        if (in_ch) begin
            // Operand/control writes to a channel still queued or running are refused
            case (adr_off)
                OFF_A: begin
                    dec_err = wb_we_i & pend_q[ch];
                    wr_a    = wb_we_i;
                    rdata   = 32'(a_q[ch]);
                end
                OFF_B: begin
                    dec_err = wb_we_i & pend_q[ch];
                    wr_b    = wb_we_i;
                    rdata   = 32'(b_q[ch]);
                end
                OFF_CTRL: begin
                    dec_err = wb_we_i & pend_q[ch];
                    wr_ctrl = wb_we_i;
                    rdata   = 32'(op_q[ch]) | (32'(pend_q[ch]) << CTRL_PEND_BIT);
                end
                OFF_RESULT: begin
                    dec_err = wb_we_i;
                    rdata   = 32'(res_q[ch]);
                end
                default: ;
            endcase
        end else if (in_glb) begin
            case (adr_off)
                OFF_DONE: begin
                    dec_err  = 1'b0;
                    done_clr = wb_we_i ? wb_dat_i[NUM_CH-1:0] : '0;
                    rdata    = 32'(done_q);
                end
                OFF_IRQ_EN: begin
                    dec_err = 1'b0;
                    irq_wr  = wb_we_i;
                    rdata   = 32'(irq_en_q);
                end
                OFF_OVF: begin
                    dec_err = 1'b0;
                    ovf_clr = wb_we_i ? wb_dat_i[NUM_CH-1:0] : '0;
                    rdata   = 32'(ovf_q);
                end
                OFF_ID: begin
                    dec_err = wb_we_i;
                    rdata   = id_word(NUM_CH, DATA_W);
                end
                default: ;
            endcase
        end
    end

    assign start_mask = (wr_fire && wr_ctrl && wb_dat_i[CTRL_START_BIT]) ? (NUM_CH'(1) << ch) : '0;
    assign eng_mask   = eng_done ? (NUM_CH'(1) << eng_ch) : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req & ~dec_err;
            wb_err_o <= req & dec_err;
            if (req) wb_dat_o <= (!wb_we_i && !dec_err) ? rdata : '0;
        end
    end

    // Engine set terms are OR'd in last so they win over a same-cycle W1C
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
                op_q[i]  <= OP_ADD;
            end
            pend_q   <= '0;
            done_q   <= '0;
            ovf_q    <= '0;
            irq_en_q <= '0;
        end else begin
            if (wr_fire && wr_a)    a_q[ch]  <= wb_dat_i[DATA_W-1:0];
            if (wr_fire && wr_b)    b_q[ch]  <= wb_dat_i[DATA_W-1:0];
            if (wr_fire && wr_ctrl) op_q[ch] <= op_e'(wb_dat_i[1:0]);
            if (wr_fire && irq_wr)  irq_en_q <= wb_dat_i[NUM_CH-1:0];
            if (eng_done)           res_q[eng_ch] <= eng_result;
            pend_q <= (pend_q | start_mask) & ~eng_mask;
            done_q <= (done_q & ~(wr_fire ? done_clr : '0) & ~start_mask) | eng_mask;
            ovf_q  <= (ovf_q & ~(wr_fire ? ovf_clr : '0) & ~start_mask) | (eng_ovf ? eng_mask : '0);
        end
    end

    accel_mc_engine #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_engine (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .pending (pend_q),
        .a_regs  (a_q),
        .b_regs  (b_q),
        .op_regs (op_q),
        .done    (eng_done),
        .done_ch (eng_ch),
        .result  (eng_result),
        .ovf     (eng_ovf)
    );

    assign int_o     = |(done_q & irq_en_q);
    assign wb_rty_o  = 1'b0;
    assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i};

endmodule

// File: tb/tb_accel_mc_top.sv
// Scoreboard bench for accel_mc_top: bus tasks queue expected responses, a monitor checks them.
module tb_accel_mc_top;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADR_W  = 8;
    localparam logic [31:0] ID_EXP = 32'hAC04_1001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;
    logic [7:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o, int_o;

    always #5 clk = ~clk;

    accel_mc_top #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .ADR_W  (ADR_W)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .int_o    (int_o)
    );

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cap_q[$];
    logic cap_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wb_ack_o || wb_err_o)) begin
            if (sb_q.size() == 0) begin
                check("unexpected response", 32'(wb_ack_o | wb_err_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, " err flag"}, 32'(wb_err_o), 32'(e.err));
                if (e.chk) check({e.name, " data"}, wb_dat_o, e.dat);
            end
        end
    end

    always @(negedge clk) begin
        if (cap_en && dut.eng_done) cap_q.push_back(int'(dut.eng_ch));
    end

    task automatic wb_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                             input logic e_err, input logic chk, input logic [31:0] e_dat,
                             input string name);
        exp_t x;
        logic got;
        x.err  = e_err;
        x.chk  = chk;
        x.dat  = e_dat;
        x.name = name;
        sb_q.push_back(x);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = wb_ack_o | wb_err_o;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({name, " handshake"}, 32'(got), 32'd1);
        if (!got) void'(sb_q.pop_back());
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input string name);
        wb_access(1'b1, a, d, 1'b0, 1'b0, '0, name);
    endtask

    task automatic wr_err(input logic [7:0] a, input logic [31:0] d, input string name);
        wb_access(1'b1, a, d, 1'b1, 1'b0, '0, name);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string name);
        wb_access(1'b0, a, '0, 1'b0, 1'b1, e, name);
    endtask

    task automatic rd_err(input logic [7:0] a, input string name);
        wb_access(1'b0, a, '0, 1'b1, 1'b0, '0, name);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after the start write returns (in its ack cycle T): int_o low at T+n-1, high at T+n
    task automatic lat_check(input string name, input int n);
        repeat (n - 1) @(negedge clk);
        check({name, " int_o before done"}, 32'(int_o), 32'd0);
        @(negedge clk);
        check({name, " int_o at done"}, 32'(int_o), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        exp_order = '{1, 2, 3, 1};

        wait_cyc(3);
        check("reset ack", 32'(wb_ack_o), 32'd0);
        check("reset err", 32'(wb_err_o), 32'd0);
        check("reset rty", 32'(wb_rty_o), 32'd0);
        check("reset int_o", 32'(int_o), 32'd0);
        check("reset dat_o", wb_dat_o, 32'd0);
        rst_n = 1'b1;

        rd(8'h8C, ID_EXP, "id read");
        rd_err(8'h40, "ch4 read");
        wr_err(8'h8C, 32'h1, "id write");
        rd_err(8'h90, "unmapped global read");
        wr_err(8'h0C, 32'h5, "result write");
        check("int_o idle", 32'(int_o), 32'd0);

        wr(8'h84, 32'h1, "irq_en ch0");
        wr(8'h00, 32'hFFFF, "ch0 A");
        wr(8'h04, 32'h0002, "ch0 B");
        wr(8'h08, 32'h100, "ch0 add start");
        lat_check("ch0 add", 4);
        rd(8'h0C, 32'h0001, "ch0 add result");
        rd(8'h88, 32'h1, "ovf after add");
        rd(8'h80, 32'h1, "done after add");

        wr(8'h08, 32'h102, "ch0 satadd start");
        wait_cyc(6);
        rd(8'h0C, 32'hFFFF, "ch0 satadd result");
        rd(8'h88, 32'h1, "ovf after satadd");
        rd(8'h08, 32'h2, "ch0 ctrl readback");

        wr(8'h10, 32'h3, "ch1 A");
        wr(8'h14, 32'h5, "ch1 B");
        wr(8'h18, 32'h101, "ch1 sub start");
        rd(8'h18, 32'h201, "ch1 ctrl pending");
        wait_cyc(6);
        rd(8'h1C, 32'hFFFE, "ch1 sub result");
        rd(8'h88, 32'h3, "ovf after sub");

        wr(8'h84, 32'h4, "irq_en ch2");
        wr(8'h20, 32'h0100, "ch2 A");
        wr(8'h24, 32'h0101, "ch2 B");
        wr(8'h28, 32'h103, "ch2 mul start");
        lat_check("ch2 mul", 19);
        rd(8'h2C, 32'h0100, "ch2 mul result");
        rd(8'h88, 32'h7, "ovf after mul");

        // ch1 MUL occupies the engine; its completion leaves the pointer at ch2
        wr(8'h30, 32'h0010, "ch3 A");
        wr(8'h34, 32'h0020, "ch3 B");
        cap_en = 1'b1;
        wr(8'h18, 32'h103, "ch1 mul start");
        wr(8'h38, 32'h100, "ch3 add start");
        wr(8'h28, 32'h103, "ch2 mul restart");
        wr_err(8'h30, 32'h1234, "ch3 A while pending");
        wait_cyc(16);
        wr(8'h10, 32'h7, "ch1 A reload");
        wr(8'h14, 32'h1, "ch1 B reload");
        wr(8'h18, 32'h100, "ch1 add start");
        wait_cyc(40);
        cap_en = 1'b0;
        check("completion count", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_q.size()) check($sformatf("completion order %0d", i), 32'(cap_q[i]), 32'(exp_order[i]));
        end
        rd(8'h3C, 32'h0030, "ch3 add result");
        rd(8'h30, 32'h0010, "ch3 A unchanged");
        rd(8'h1C, 32'h0008, "ch1 add result");
        rd(8'h2C, 32'h0100, "ch2 mul result again");
        rd(8'h80, 32'hF, "done after rr");
        rd(8'h88, 32'h5, "ovf after rr");

        wr(8'h84, 32'h5, "irq_en 5");
        check("int_o with done0", 32'(int_o), 32'd1);
        wr(8'h80, 32'h4, "w1c done2");
        check("int_o after clear ch2", 32'(int_o), 32'd1);
        wr(8'h80, 32'h1, "w1c done0");
        check("int_o after clear ch0", 32'(int_o), 32'd0);
        rd(8'h80, 32'hA, "done after w1c");
        rd(8'h84, 32'h5, "irq_en readback");

        // W1C accepted on the same edge the engine sets DONE[0]
        wr(8'h08, 32'h100, "ch0 add for race");
        wait_cyc(2);
        wr(8'h80, 32'h1, "w1c racing engine");
        check("int_o after race", 32'(int_o), 32'd1);
        rd(8'h80, 32'hB, "done after race");
        rd(8'h88, 32'h5, "ovf after race");

        wr(8'h28, 32'h103, "ch2 mul before reset");
        rd(8'h8C, ID_EXP, "id before reset");
        wait_cyc(6);
        check("int_o before reset", 32'(int_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset int_o", 32'(int_o), 32'd0);
        check("async reset ack", 32'(wb_ack_o), 32'd0);
        check("async reset err", 32'(wb_err_o), 32'd0);
        check("async reset dat_o", wb_dat_o, 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;

        rd(8'h28, 32'h0, "ch2 ctrl after reset");
        rd(8'h80, 32'h0, "done after reset");
        rd(8'h88, 32'h0, "ovf after reset");
        rd(8'h2C, 32'h0, "ch2 result after reset");
        rd(8'h84, 32'h0, "irq_en after reset");
        wr(8'h84, 32'h4, "irq_en ch2 post reset");
        wr(8'h20, 32'h0100, "ch2 A post reset");
        wr(8'h24, 32'h0101, "ch2 B post reset");
        wr(8'h28, 32'h103, "ch2 mul post reset");
        lat_check("ch2 mul post reset", 19);
        rd(8'h2C, 32'h0100, "ch2 result post reset");
        rd(8'h88, 32'h4, "ovf post reset");

        wait_cyc(2);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
